// File: rtl/cca_energy_detect.sv
// Clear-channel-assessment energy detector: 4-sample RSSI moving average feeding a
// debounced, hysteretic busy/idle state machine with busy-period length and peak tracking.
module cca_energy_detect #(
  parameter int unsigned RSSI_HALF_DB_WIDTH = 11,
  parameter int unsigned CONFIRM_WIDTH      = 4,
  parameter int unsigned BUSY_LEN_WIDTH     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [RSSI_HALF_DB_WIDTH-1:0] i_rssi_half_db,
  input  logic                          i_rssi_half_db_valid,
  input  logic [RSSI_HALF_DB_WIDTH-1:0] i_rssi_th,
  input  logic [3:0]                    i_rssi_hyst,
  input  logic [CONFIRM_WIDTH-1:0]      i_busy_confirm,
  input  logic [CONFIRM_WIDTH-1:0]      i_idle_confirm,
  input  logic                          i_tx_active,
  output logic                          o_ch_idle,
  output logic                          o_busy_start_strobe,
  output logic                          o_busy_end_strobe,
  output logic [BUSY_LEN_WIDTH-1:0]     o_busy_len,
  output logic [RSSI_HALF_DB_WIDTH-1:0] o_rssi_peak_half_db,
  output logic [RSSI_HALF_DB_WIDTH-1:0] o_rssi_avg_half_db,
  output logic                          o_rssi_avg_valid
);

  localparam int unsigned W  = RSSI_HALF_DB_WIDTH;
  localparam int unsigned SW = W + 2;
  localparam int unsigned TW = W + 1;
  localparam int unsigned CW = CONFIRM_WIDTH;
  localparam int unsigned LW = BUSY_LEN_WIDTH;

  localparam logic [W-1:0]  PEAK_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [LW-1:0] LEN_MAX  = '1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Moving average: three stored samples plus the incoming one
  // ---------------------------------------------------------------------------
  logic [W-1:0]  r_hist [0:2];
  logic [1:0]    r_fill;
  logic [W-1:0]  r_avg;
  logic          r_avg_valid;

  logic signed [SW-1:0] w_sum;
  logic [W-1:0]         w_avg_calc;

  assign w_sum = $signed({{2{i_rssi_half_db[W-1]}}, i_rssi_half_db})
               + $signed({{2{r_hist[0][W-1]}}, r_hist[0]})
               + $signed({{2{r_hist[1][W-1]}}, r_hist[1]})
               + $signed({{2{r_hist[2][W-1]}}, r_hist[2]});

  // Dropping the two LSBs of the signed sum is an arithmetic floor divide by 4
  assign w_avg_calc = w_sum[SW-1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist[0]   <= '0;
      r_hist[1]   <= '0;
      r_hist[2]   <= '0;
      r_fill      <= '0;
      r_avg       <= '0;
      r_avg_valid <= 1'b0;
    end else begin
      r_avg_valid <= 1'b0;
      if (i_rssi_half_db_valid) begin
        r_hist[0] <= i_rssi_half_db;
        r_hist[1] <= r_hist[0];
        r_hist[2] <= r_hist[1];
        if (r_fill == 2'd3) begin
          r_avg       <= w_avg_calc;
          r_avg_valid <= 1'b1;
        end else begin
          r_fill <= r_fill + 2'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Threshold comparison (idle threshold widened by one bit so it cannot wrap)
  // ---------------------------------------------------------------------------
  logic [TW-1:0]  w_avg_ext;
  logic [TW-1:0]  w_th_ext;
  logic [TW-1:0]  w_idle_th;
  logic           w_above;
  logic           w_below;
  logic [CW-1:0]  w_busy_cfm;
  logic [CW-1:0]  w_idle_cfm;

  assign w_avg_ext  = {r_avg[W-1], r_avg};
  assign w_th_ext   = {i_rssi_th[W-1], i_rssi_th};
  assign w_idle_th  = w_th_ext - TW'(i_rssi_hyst);
  assign w_above    = $signed(w_avg_ext) >= $signed(w_th_ext);
  assign w_below    = $signed(w_avg_ext) <  $signed(w_idle_th);
  assign w_busy_cfm = (i_busy_confirm == '0) ? CNT_ONE : i_busy_confirm;
  assign w_idle_cfm = (i_idle_confirm == '0) ? CNT_ONE : i_idle_confirm;

  // ---------------------------------------------------------------------------
  // Busy/idle state machine
  // ---------------------------------------------------------------------------
  state_t         r_state;
  logic [CW-1:0]  r_up_cnt;
  logic [CW-1:0]  r_dn_cnt;

  state_t         w_state_nxt;
  logic [CW-1:0]  w_up_nxt;
  logic [CW-1:0]  w_dn_nxt;
  logic [CW-1:0]  w_up_inc;
  logic [CW-1:0]  w_dn_inc;
  logic           w_enter;
  logic           w_exit;

  assign w_up_inc = r_up_cnt + CNT_ONE;
  assign w_dn_inc = r_dn_cnt + CNT_ONE;

  always_comb begin
    w_state_nxt = r_state;
    w_up_nxt    = r_up_cnt;
    w_dn_nxt    = r_dn_cnt;
    w_enter     = 1'b0;
    w_exit      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_tx_active) begin
          w_state_nxt = ST_BUSY;
          w_enter     = 1'b1;
          w_up_nxt    = '0;
          w_dn_nxt    = '0;
        end else if (r_avg_valid) begin
          if (w_above) begin
            if (w_up_inc >= w_busy_cfm) begin
              w_state_nxt = ST_BUSY;
              w_enter     = 1'b1;
              w_up_nxt    = '0;
              w_dn_nxt    = '0;
            end else begin
              w_up_nxt = w_up_inc;
            end
          end else begin
            w_up_nxt = '0;
          end
        end
      end
      ST_BUSY: begin
        // Own transmission keeps the debounce pinned so exit waits for tx to drop
        if (i_tx_active) begin
          w_dn_nxt = '0;
        end else if (r_avg_valid) begin
          if (w_below) begin
            if (w_dn_inc >= w_idle_cfm) begin
              w_state_nxt = ST_IDLE;
              w_exit      = 1'b1;
              w_up_nxt    = '0;
              w_dn_nxt    = '0;
            end else begin
              w_dn_nxt = w_dn_inc;
            end
          end else begin
            w_dn_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_up_nxt    = '0;
        w_dn_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_up_cnt <= '0;
      r_dn_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_up_cnt <= w_up_nxt;
      r_dn_cnt <= w_dn_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered status: strobes, busy-period length and peak
  // ---------------------------------------------------------------------------
  logic           r_ch_idle;
  logic           r_start_stb;
  logic           r_end_stb;
  logic [LW-1:0]  r_busy_len;
  logic [W-1:0]   r_peak;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch_idle   <= 1'b1;
      r_start_stb <= 1'b0;
      r_end_stb   <= 1'b0;
      r_busy_len  <= '0;
      r_peak      <= PEAK_MIN;
    end else begin
      r_ch_idle   <= (w_state_nxt == ST_IDLE);
      r_start_stb <= w_enter;
      r_end_stb   <= w_exit;
      if (w_enter) begin
        // An average arriving on the entry cycle is the first one of the period
        r_busy_len <= r_avg_valid ? LW'(1) : '0;
        r_peak     <= r_avg_valid ? r_avg : PEAK_MIN;
      end else if ((r_state == ST_BUSY) && r_avg_valid) begin
        if (r_busy_len != LEN_MAX) begin
          r_busy_len <= r_busy_len + LW'(1);
        end
        if ($signed(r_avg) > $signed(r_peak)) begin
          r_peak <= r_avg;
        end
      end
    end
  end

  assign o_ch_idle           = r_ch_idle;
  assign o_busy_start_strobe = r_start_stb;
  assign o_busy_end_strobe   = r_end_stb;
  assign o_busy_len          = r_busy_len;
  assign o_rssi_peak_half_db = r_peak;
  assign o_rssi_avg_half_db  = r_avg;
  assign o_rssi_avg_valid    = r_avg_valid;

endmodule

// File: tb/tb_cca_energy_detect.sv
// Directed self-checking bench for cca_energy_detect: averaging, debounce,
// hysteresis, peak/length tracking, tx override, saturation and mid-busy reset.
module tb_cca_energy_detect;

  localparam int W  = 11;
  localparam int CW = 4;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  rssi;
  logic          rssi_valid;
  logic [W-1:0]  rssi_th;
  logic [3:0]    rssi_hyst;
  logic [CW-1:0] busy_confirm;
  logic [CW-1:0] idle_confirm;
  logic          tx_active;
  logic          ch_idle;
  logic          start_stb;
  logic          end_stb;
  logic [LW-1:0] busy_len;
  logic [W-1:0]  peak;
  logic [W-1:0]  avg;
  logic          avg_valid;

  int n_chk = 0;
  int n_err = 0;
  int obs_av;
  int obs_avg;

  always #5 clk = ~clk;

  cca_energy_detect #(
    .RSSI_HALF_DB_WIDTH (W),
    .CONFIRM_WIDTH      (CW),
    .BUSY_LEN_WIDTH     (LW)
  ) u_dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_rssi_half_db       (rssi),
    .i_rssi_half_db_valid (rssi_valid),
    .i_rssi_th            (rssi_th),
    .i_rssi_hyst          (rssi_hyst),
    .i_busy_confirm       (busy_confirm),
    .i_idle_confirm       (idle_confirm),
    .i_tx_active          (tx_active),
    .o_ch_idle            (ch_idle),
    .o_busy_start_strobe  (start_stb),
    .o_busy_end_strobe    (end_stb),
    .o_busy_len           (busy_len),
    .o_rssi_peak_half_db  (peak),
    .o_rssi_avg_half_db   (avg),
    .o_rssi_avg_valid     (avg_valid)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int s_avg();
    return int'($signed(avg));
  endfunction

  function automatic int s_peak();
    return int'($signed(peak));
  endfunction

  // One sample; records the average strobe one cycle later, returns once the FSM has reacted
  task automatic send(input int v);
    rssi       = W'(v);
    rssi_valid = 1'b1;
    @(negedge clk);
    obs_av     = int'(avg_valid);
    obs_avg    = s_avg();
    rssi_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_ch_idle"}, int'(ch_idle), 1);
    chk({pfx, "_start"},   int'(start_stb), 0);
    chk({pfx, "_end"},     int'(end_stb), 0);
    chk({pfx, "_len"},     int'(busy_len), 0);
    chk({pfx, "_peak"},    s_peak(), -1024);
    chk({pfx, "_avg"},     s_avg(), 0);
    chk({pfx, "_avg_vld"}, int'(avg_valid), 0);
  endtask

  initial begin
    rst          = 1'b1;
    rssi         = '0;
    rssi_valid   = 1'b0;
    rssi_th      = W'(300);
    rssi_hyst    = 4'd0;
    busy_confirm = CW'(1);
    idle_confirm = CW'(1);
    tx_active    = 1'b0;

    // Reset state and first-average latency
    do_reset();
    chk_reset_outputs("rst");
    for (int i = 0; i < 3; i++) begin
      send(200);
      chk("fill_no_avg", obs_av, 0);
    end
    send(200);
    chk("first_avg_vld", obs_av, 1);
    chk("first_avg", obs_avg, 200);
    chk("below_th_idle", int'(ch_idle), 1);

    // Floor average of negative samples, then 3-average busy debounce
    do_reset();
    rssi_th      = W'(100);
    busy_confirm = CW'(3);
    send(-4); send(-3); send(-2); send(-1);
    chk("neg_floor_avg", obs_avg, -3);
    send(150); chk("ramp_avg1", obs_avg, 36);
    send(150); chk("ramp_avg2", obs_avg, 74);
    send(150); chk("ramp_avg3", obs_avg, 112);
    chk("debounce1_idle", int'(ch_idle), 1);
    send(150);
    chk("debounce2_idle", int'(ch_idle), 1);
    chk("debounce2_nostart", int'(start_stb), 0);
    send(150);
    chk("busy_start", int'(start_stb), 1);
    chk("busy_ch", int'(ch_idle), 0);
    chk("busy_len_entry", int'(busy_len), 1);
    chk("busy_peak_entry", s_peak(), 150);
    @(negedge clk);
    chk("start_one_cycle", int'(start_stb), 0);

    // Hysteresis: idle threshold 90, two consecutive lows required
    rssi_hyst    = 4'd10;
    idle_confirm = CW'(2);
    for (int i = 0; i < 6; i++) send(95);
    chk("hyst_avg95", obs_avg, 95);
    chk("hyst_hold_busy", int'(ch_idle), 0);
    send(89); send(89); send(89); send(89);
    chk("hyst_avg89a", obs_avg, 89);
    chk("hyst_no_end_a", int'(end_stb), 0);
    send(97);
    chk("hyst_avg91", obs_avg, 91);
    chk("hyst_still_busy", int'(ch_idle), 0);
    send(81);
    chk("hyst_avg89b", obs_avg, 89);
    chk("hyst_no_end_b", int'(end_stb), 0);
    chk("hyst_len", int'(busy_len), 13);
    send(89);
    chk("hyst_avg89c", obs_avg, 89);
    chk("hyst_end", int'(end_stb), 1);
    chk("hyst_idle", int'(ch_idle), 1);
    chk("hyst_peak", s_peak(), 150);

    // Peak and length tracking, held after the end strobe
    do_reset();
    rssi_th      = W'(100);
    rssi_hyst    = 4'd0;
    busy_confirm = CW'(1);
    idle_confirm = CW'(1);
    for (int i = 0; i < 4; i++) send(0);
    send(480);
    chk("pk_avg120", obs_avg, 120);
    chk("pk_start", int'(start_stb), 1);
    send(240);
    chk("pk_avg180", obs_avg, 180);
    send(-120);
    chk("pk_avg150", obs_avg, 150);
    chk("pk_len3", int'(busy_len), 3);
    chk("pk_peak_busy", s_peak(), 180);
    send(-300);
    chk("pk_avg75", obs_avg, 75);
    chk("pk_end", int'(end_stb), 1);
    chk("pk_peak_end", s_peak(), 180);
    send(0);
    chk("pk_avg_m45", obs_avg, -45);
    chk("pk_peak_held", s_peak(), 180);
    chk("pk_end_cleared", int'(end_stb), 0);

    // Transmit override in idle, exit only after idle_confirm averages post-tx
    do_reset();
    idle_confirm = CW'(4);
    for (int i = 0; i < 4; i++) send(-200);
    chk("tx_pre_idle", int'(ch_idle), 1);
    tx_active = 1'b1;
    @(negedge clk);
    tx_active = 1'b0;
    chk("tx_start", int'(start_stb), 1);
    chk("tx_ch", int'(ch_idle), 0);
    chk("tx_len0", int'(busy_len), 0);
    chk("tx_peak_min", s_peak(), -1024);
    send(-200); send(-200); send(-200);
    chk("tx_len3", int'(busy_len), 3);
    chk("tx_no_end3", int'(end_stb), 0);
    chk("tx_busy3", int'(ch_idle), 0);
    send(-200);
    chk("tx_end4", int'(end_stb), 1);
    chk("tx_idle4", int'(ch_idle), 1);

    // Full-rate stream, length saturation, then reset mid-busy
    do_reset();
    idle_confirm = CW'(1);
    rssi         = W'(500);
    rssi_valid   = 1'b1;
    repeat (10) @(negedge clk);
    chk("fr_avg_vld", int'(avg_valid), 1);
    chk("fr_avg", s_avg(), 500);
    chk("fr_busy", int'(ch_idle), 0);
    repeat (70000) @(negedge clk);
    chk("sat_len", int'(busy_len), 65535);
    rssi_valid = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_no_end", int'(end_stb), 0);
    send(500); send(500); send(500);
    chk("refill_no_avg", obs_av, 0);
    send(500);
    chk("refill_avg_vld", obs_av, 1);
    chk("refill_avg", obs_avg, 500);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cca_energy_detect.md
# cca_energy_detect

Clear-channel-assessment energy detector in the xpu receive path. It consumes the 0.5 dB-step RSSI stream produced by the RSSI block, smooths it with a 4-sample moving average and runs a debounced, hysteretic busy/idle state machine. It reports channel state, start/end strobes, busy-period length and peak RSSI to the MAC-side CSMA logic. Transmit activity forces the channel busy regardless of RSSI.

## Interface

Parameters:
- RSSI_HALF_DB_WIDTH, 11, width of signed RSSI input and thresholds (0.5 dB/LSB)
- CONFIRM_WIDTH, 4, width of debounce count controls
- BUSY_LEN_WIDTH, 16, width of busy-duration counter

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rssi_half_db  in  RSSI_HALF_DB_WIDTH  signed RSSI sample
- rssi_half_db_valid  in  1  sample strobe
- rssi_th  in  RSSI_HALF_DB_WIDTH  signed busy threshold
- rssi_hyst  in  4  unsigned hysteresis; idle threshold = rssi_th − rssi_hyst
- busy_confirm  in  CONFIRM_WIDTH  consecutive above-threshold averages to declare busy (0 treated as 1)
- idle_confirm  in  CONFIRM_WIDTH  consecutive below-idle-threshold averages to declare idle (0 treated as 1)
- tx_active  in  1  transmitter on air; forces busy
- ch_idle  out  1  1 = channel idle
- busy_start_strobe  out  1  one-cycle pulse on idle→busy
- busy_end_strobe  out  1  one-cycle pulse on busy→idle
- busy_len  out  BUSY_LEN_WIDTH  averages counted in current/last busy period, saturating
- rssi_peak_half_db  out  RSSI_HALF_DB_WIDTH  signed maximum average in current/last busy period
- rssi_avg_half_db  out  RSSI_HALF_DB_WIDTH  signed moving average
- rssi_avg_valid  out  1  average strobe

## Operation

- Reset: ch_idle=1, strobes=0, busy_len=0, rssi_peak_half_db=−2^(W−1), rssi_avg_half_db=0, rssi_avg_valid=0, FSM=IDLE, history, fill count and confirm counters cleared.
- Averager: 4-deep history shifts on each rssi_half_db_valid. Sum in W+2 signed bits; avg = sum >>> 2 (arithmetic, floor). rssi_avg_valid asserts only after 4 samples since reset (first three samples produce no average).
- Idle threshold computed in W+1 signed bits (no wrap): idle_th = rssi_th − rssi_hyst.
- FSM, evaluated only on rssi_avg_valid unless noted:
  - IDLE: avg ≥ rssi_th increments up_cnt, else up_cnt=0. up_cnt reaching max(busy_confirm,1) → BUSY.
  - BUSY: avg < idle_th increments dn_cnt, else dn_cnt=0. dn_cnt reaching max(idle_confirm,1) → IDLE.
  - tx_active=1 in IDLE → BUSY on that cycle, independent of valid. In BUSY, tx_active=1 holds dn_cnt at 0, so exit cannot occur until idle_confirm averages after tx_active drops.
  - Each transition clears both counters.
- Entering BUSY: busy_start_strobe=1, busy_len=0, peak=−2^(W−1). Each average while BUSY (including the entry average): busy_len += 1, saturating at all-ones; peak = max(peak, avg). Values held after busy→idle until next busy start.
- Exiting: busy_end_strobe=1; ch_idle=1.
- Threshold/confirm inputs are used live; changes take effect on the next average.

## Timing

- rssi_half_db_valid at cycle t → rssi_avg_valid/rssi_avg_half_db at t+1 → ch_idle, strobes, busy_len, peak updated at t+2.
- tx_active rising at cycle t (in IDLE) → ch_idle=0 and busy_start_strobe at t+1.
- Strobes are exactly one cycle; start and end never in the same cycle.
- tx_active and a qualifying average in the same cycle: single transition, single strobe.
- Back-to-back valid samples (every cycle) are supported at full rate.
- rst mid-busy: next cycle all outputs at reset values, no busy_end_strobe emitted; 4 new samples required before averaging resumes.

## Test plan

- Reset then 3 samples of 200: no rssi_avg_valid; 4th sample → rssi_avg_half_db=200 one cycle later, ch_idle stays 1 with rssi_th=300.
- rssi_th=100, busy_confirm=3: samples −4,−3,−2,−1 → avg=−3 (floor of −2.5); then stream of 150 → busy_start_strobe after exactly 3 consecutive averages ≥100, ch_idle=0.
- Hysteresis: busy at th=100, hyst=10, idle_confirm=2; averages 95,95,95 → stays busy; 89,91,89,89 → counter resets on 91, busy_end_strobe on the second consecutive 89.
- Peak/length: busy with averages 120,180,150 then idle → rssi_peak_half_db=180, busy_len counts all busy averages, values held after end strobe.
- tx_active pulse while IDLE with RSSI −200: busy_start_strobe next cycle; after tx_active drops, idle_confirm=4 → busy_end_strobe on 4th average.
- Saturation and reset: busy for 70000 averages (BUSY_LEN_WIDTH=16) → busy_len=0xFFFF; assert rst mid-busy → ch_idle=1, no busy_end_strobe, busy_len=0.
